// File: rtl/key_debounce_if.sv
`default_nettype none
//============================================================================
// Module   : key_debounce_if
// Purpose  : Raw key pins in, debounced levels and event pulses out.
// Revision : 1.0 - initial release
//============================================================================
interface key_debounce_if #(
    parameter int NUM_KEYS = 2
);
    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_long;

    // master: drives the pins and consumes the events
    modport master (
        output key_in,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_long
    );

    // slave: the debouncer itself
    modport slave (
        input  key_in,
        output key_level,
        output key_press,
        output key_release,
        output key_long
    );
endinterface
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
//============================================================================
// Module   : key_debounce
// Purpose  : Per-key synchronizer, 4-state debounce FSM and long-press
//            detection. Define KEY_REPEAT_EN for auto-repeat key_press.
// Revision : 1.0 - initial release
//============================================================================
module key_debounce #(
    parameter int NUM_KEYS          = 2,
    parameter int DEBOUNCE_CYCLES   = 200,
    parameter int LONG_PRESS_CYCLES = 1000,
    parameter int ACTIVE_LOW        = 1,
    parameter int REPEAT_CYCLES     = 250
) (
    input  logic          clk,
    input  logic          rst,
    key_debounce_if.slave bus
);

    localparam int   c_DCNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int   c_HCNT_W   = $clog2(LONG_PRESS_CYCLES) + 1;
    localparam logic c_RELEASED = (ACTIVE_LOW != 0);

    localparam logic [c_DCNT_W-1:0] c_DCNT_LAST = c_DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_HCNT_W-1:0] c_HOLD_MAX  = c_HCNT_W'(LONG_PRESS_CYCLES);
    localparam logic [c_HCNT_W-1:0] c_HOLD_LAST = c_HCNT_W'(LONG_PRESS_CYCLES - 1);

`ifdef KEY_REPEAT_EN
    localparam int                  c_RCNT_W    = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [c_RCNT_W-1:0] c_RCNT_LAST = c_RCNT_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 24) ||
        LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 1) begin : g_param_check
        $error("key_debounce: illegal parameter combination");
    end

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        logic [1:0]          r_sync;
        logic                r_p;
        state_t              r_state;
        state_t              w_state_nx;
        logic [c_DCNT_W-1:0] r_dcnt;
        logic [c_DCNT_W-1:0] w_dcnt_nx;
        logic [c_HCNT_W-1:0] r_hcnt;
        logic [c_HCNT_W-1:0] w_hcnt_nx;
        logic                w_press;
        logic                w_release;
        logic                w_long;
        logic                r_level;
        logic                r_press;
        logic                r_release;
        logic                r_long;
`ifdef KEY_REPEAT_EN
        logic [c_RCNT_W-1:0] r_rcnt;
        logic [c_RCNT_W-1:0] w_rcnt_nx;
`endif

        // Synchronizer resets to the released pin level; r_p is 1 when pressed.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync <= {2{c_RELEASED}};
                r_p    <= 1'b0;
            end else begin
                r_sync <= {r_sync[0], bus.key_in[g]};
                r_p    <= r_sync[1] ^ c_RELEASED;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state   <= S_IDLE;
                r_dcnt    <= '0;
                r_hcnt    <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_long    <= 1'b0;
            end else begin
                r_state   <= w_state_nx;
                r_dcnt    <= w_dcnt_nx;
                r_hcnt    <= w_hcnt_nx;
                r_level   <= (w_state_nx == S_PRESSED) || (w_state_nx == S_RELEASE_WAIT);
                r_press   <= w_press;
                r_release <= w_release;
                r_long    <= w_long;
            end
        end

`ifdef KEY_REPEAT_EN
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rcnt <= '0;
            end else begin
                r_rcnt <= w_rcnt_nx;
            end
        end
`endif

        always_comb begin
            w_state_nx = r_state;
            w_dcnt_nx  = r_dcnt;
            w_hcnt_nx  = r_hcnt;
            w_press    = 1'b0;
            w_release  = 1'b0;
            w_long     = 1'b0;
`ifdef KEY_REPEAT_EN
            w_rcnt_nx  = r_rcnt;
`endif
            unique case (r_state)
                S_IDLE: begin
                    if (r_p) begin
                        w_state_nx = S_PRESS_WAIT;
                        w_dcnt_nx  = c_DCNT_W'(1);
                    end
                end
                S_PRESS_WAIT: begin
                    if (!r_p) begin
                        w_state_nx = S_IDLE;
                        w_dcnt_nx  = '0;
                    end else if (r_dcnt == c_DCNT_LAST) begin
                        w_state_nx = S_PRESSED;
                        w_dcnt_nx  = '0;
                        w_hcnt_nx  = '0;
                        w_press    = 1'b1;
`ifdef KEY_REPEAT_EN
                        w_rcnt_nx  = '0;
`endif
                    end else begin
                        w_dcnt_nx = r_dcnt + 1'b1;
                    end
                end
                S_PRESSED: begin
                    if (!r_p) begin
                        w_state_nx = S_RELEASE_WAIT;
                        w_dcnt_nx  = c_DCNT_W'(1);
                    end else if (r_hcnt != c_HOLD_MAX) begin
                        w_hcnt_nx = r_hcnt + 1'b1;
                        w_long    = (r_hcnt == c_HOLD_LAST);
                    end
`ifdef KEY_REPEAT_EN
                    // Repeat counting starts only once the hold counter has saturated.
                    else if (r_rcnt == c_RCNT_LAST) begin
                        w_rcnt_nx = '0;
                        w_press   = 1'b1;
                    end else begin
                        w_rcnt_nx = r_rcnt + 1'b1;
                    end
`endif
                end
                S_RELEASE_WAIT: begin
                    // A short release glitch returns to PRESSED with hold/repeat frozen.
                    if (r_p) begin
                        w_state_nx = S_PRESSED;
                        w_dcnt_nx  = '0;
                    end else if (r_dcnt == c_DCNT_LAST) begin
                        w_state_nx = S_IDLE;
                        w_dcnt_nx  = '0;
                        w_release  = 1'b1;
                    end else begin
                        w_dcnt_nx = r_dcnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end

        assign bus.key_level[g]   = r_level;
        assign bus.key_press[g]   = r_press;
        assign bus.key_release[g] = r_release;
        assign bus.key_long[g]    = r_long;
    end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
//============================================================================
// Module   : tb_key_debounce
// Purpose  : Directed stimulus for key_debounce with a run-length reference
//            model compared every cycle, plus literal timing checks.
// Revision : 1.0 - initial release
//============================================================================
module tb_key_debounce;

    localparam int NK = 2;
    localparam int D  = 4;
    localparam int L  = 20;
    localparam int R  = 5;
    localparam int AL = 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    key_debounce_if #(.NUM_KEYS(NK)) bus ();

    key_debounce #(
        .NUM_KEYS          (NK),
        .DEBOUNCE_CYCLES   (D),
        .LONG_PRESS_CYCLES (L),
        .ACTIVE_LOW        (AL),
        .REPEAT_CYCLES     (R)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Event timestamps (posedge index after which the pulse was visible).
    int pq0[$];
    int rq0[$];
    int lq0[$];
    int pq1[$];
    int rq1[$];

    // Reference model: a key's accepted level flips only after D consecutive
    // samples disagreeing with it; pins reach the decision point 3 edges late.
    bit [2:0]       m_hist  [NK];
    bit             m_level [NK];
    int             m_run   [NK];
    int             m_hold  [NK];
    int             m_rep   [NK];
    logic [NK-1:0]  e_level;
    logic [NK-1:0]  e_press;
    logic [NK-1:0]  e_rel;
    logic [NK-1:0]  e_long;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        bit p;
        bit raw_pressed;
        for (int k = 0; k < NK; k++) begin
            if (rst) begin
                m_hist[k]  = 3'b000;
                m_level[k] = 1'b0;
                m_run[k]   = 0;
                m_hold[k]  = 0;
                m_rep[k]   = 0;
                e_press[k] = 1'b0;
                e_rel[k]   = 1'b0;
                e_long[k]  = 1'b0;
            end else begin
                p          = m_hist[k][2];
                e_press[k] = 1'b0;
                e_rel[k]   = 1'b0;
                e_long[k]  = 1'b0;
                if (p != m_level[k]) begin
                    m_run[k]++;
                    if (m_run[k] == D) begin
                        m_level[k] = p;
                        m_run[k]   = 0;
                        if (p) begin
                            e_press[k] = 1'b1;
                            m_hold[k]  = 0;
                            m_rep[k]   = 0;
                        end else begin
                            e_rel[k] = 1'b1;
                        end
                    end
                end else begin
                    // Held time only grows on samples following a stable pressed sample.
                    if (m_level[k] && m_run[k] == 0) begin
                        if (m_hold[k] < L) begin
                            m_hold[k]++;
                            if (m_hold[k] == L) e_long[k] = 1'b1;
                        end
`ifdef KEY_REPEAT_EN
                        else begin
                            m_rep[k]++;
                            if (m_rep[k] == R) begin
                                m_rep[k]   = 0;
                                e_press[k] = 1'b1;
                            end
                        end
`endif
                    end
                    m_run[k] = 0;
                end
                raw_pressed = (AL != 0) ? !bus.key_in[k] : bus.key_in[k];
                m_hist[k]   = {m_hist[k][1:0], raw_pressed};
            end
            e_level[k] = m_level[k];
        end
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
            #1;
            check("level",   32'(bus.key_level),   32'(e_level));
            check("press",   32'(bus.key_press),   32'(e_press));
            check("release", 32'(bus.key_release), 32'(e_rel));
            check("long",    32'(bus.key_long),    32'(e_long));
            if (bus.key_press[0])   pq0.push_back(cyc);
            if (bus.key_release[0]) rq0.push_back(cyc);
            if (bus.key_long[0])    lq0.push_back(cyc);
            if (bus.key_press[1])   pq1.push_back(cyc);
            if (bus.key_release[1]) rq1.push_back(cyc);
        end
    end

    task automatic clear_events();
        pq0.delete(); rq0.delete(); lq0.delete(); pq1.delete(); rq1.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive at a falling edge; k is the rising edge that first samples it.
    task automatic set_keys(input logic [NK-1:0] v, output int k);
        @(negedge clk);
        bus.key_in = v;
        k = cyc + 1;
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    // Hold key 0 for len samples, optionally releasing it for one sample.
    task automatic hold_key0(input int len, input int glitch_at, output int k, output int kr);
        set_keys(2'b10, k);
        for (int i = 1; i < len; i++) begin
            @(negedge clk);
            bus.key_in[0] = (i == glitch_at);
            if (i == 20) check("mid_hold_level", 32'(bus.key_level), 32'h1);
        end
        @(negedge clk);
        bus.key_in[0] = 1'b1;
        kr = cyc + 1;
    endtask

    initial begin : stim
        int k;
        int kr;
        int k2;
        rst        = 1'b1;
        bus.key_in = 2'b11;
        idle(3);
        check("reset_outputs",
              32'({bus.key_level, bus.key_press, bus.key_release, bus.key_long}), 32'h0);
        rst = 1'b0;

        // Quiet keys after reset
        clear_events();
        idle(50);
        check("quiet_events", 32'(pq0.size() + rq0.size() + lq0.size() + pq1.size() + rq1.size()), 32'd0);
        check("quiet_level", 32'(bus.key_level), 32'h0);

        // Long hold: press, long press, release
        clear_events();
        hold_key0(40, -1, k, kr);
        idle(12);
        check("press_time", 32'(q_at(pq0, 0)), 32'(k + 6));
        check("long_count", 32'(lq0.size()), 32'd1);
        check("long_after_press", 32'(q_at(lq0, 0) - q_at(pq0, 0)), 32'd20);
        check("release_count", 32'(rq0.size()), 32'd1);
        check("release_time", 32'(q_at(rq0, 0)), 32'(kr + 6));
        check("key1_press", 32'(pq1.size()), 32'd0);
`ifdef KEY_REPEAT_EN
        check("press_count", 32'(pq0.size()), 32'd4);
        check("repeat1", 32'(q_at(pq0, 1) - q_at(lq0, 0)), 32'd5);
        check("repeat2", 32'(q_at(pq0, 2) - q_at(lq0, 0)), 32'd10);
        check("repeat3", 32'(q_at(pq0, 3) - q_at(lq0, 0)), 32'd15);
`else
        check("press_count", 32'(pq0.size()), 32'd1);
`endif
        check("level_after_release", 32'(bus.key_level), 32'h0);

        // Bounce shorter than the debounce window
        clear_events();
        set_keys(2'b10, k);
        set_keys(2'b11, k);
        set_keys(2'b10, k);
        set_keys(2'b11, k);
        idle(15);
        check("bounce_events", 32'(pq0.size() + rq0.size() + lq0.size()), 32'd0);
        check("bounce_level", 32'(bus.key_level), 32'h0);

        // Long hold with a one-sample release glitch
        clear_events();
        hold_key0(40, 15, k, kr);
        idle(12);
        check("glitch_press_time", 32'(q_at(pq0, 0)), 32'(k + 6));
        check("glitch_release_count", 32'(rq0.size()), 32'd1);
        check("glitch_release_time", 32'(q_at(rq0, 0)), 32'(kr + 6));
        check("glitch_long_count", 32'(lq0.size()), 32'd1);
        check("glitch_long_time", 32'(q_at(lq0, 0) - q_at(pq0, 0)), 32'd22);
`ifdef KEY_REPEAT_EN
        check("glitch_press_count", 32'(pq0.size()), 32'd3);
`else
        check("glitch_press_count", 32'(pq0.size()), 32'd1);
`endif

        // Both keys together
        clear_events();
        set_keys(2'b00, k);
        idle(12);
        set_keys(2'b11, kr);
        idle(12);
        check("both_press0", 32'(q_at(pq0, 0)), 32'(k + 6));
        check("both_press1", 32'(q_at(pq1, 0)), 32'(k + 6));
        check("both_release0", 32'(q_at(rq0, 0)), 32'(kr + 6));
        check("both_release1", 32'(q_at(rq1, 0)), 32'(kr + 6));

        // Reset while held
        set_keys(2'b10, k);
        idle(15);
        check("pre_reset_level", 32'(bus.key_level), 32'h1);
        clear_events();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_reset",
              32'({bus.key_level, bus.key_press, bus.key_release, bus.key_long}), 32'h0);
        idle(3);
        rst = 1'b0;
        k2  = cyc + 1;
        idle(12);
        check("reset_no_release", 32'(rq0.size()), 32'd0);
        check("reset_press_count", 32'(pq0.size()), 32'd1);
        check("reset_press_time", 32'(q_at(pq0, 0)), 32'(k2 + 6));
        check("reset_level", 32'(bus.key_level), 32'h1);
        set_keys(2'b11, kr);
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
